// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 codes, ALU operation and writeback selects.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] { WB_ALU, WB_LOAD, WB_LINK } wb_sel_e;

    // Map funct3 plus the funct7[5] "alternate" bit onto an ALU operation.
    // Callers only pass alt=1 where it is meaningful (SUB, SRA/SRAI).
    function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_core_if.sv
// Word-memory port: word index, byte-lane write enables, write data, combinational read data.
interface rv32i_core_if;
    logic [9:0]  idx;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output idx, we, be, wdata, input rdata);
    modport slave  (input idx, we, be, wdata, output rdata);
endinterface

// File: rtl/rv32i_core_mem.sv
// Generic word memory with byte-lane writes and combinational read.
// WORDS must be a power of two no larger than 1024; the index wraps modulo WORDS.
module rv32i_core_mem #(
    parameter int WORDS = 1024
) (
    input logic         clk,
    rv32i_core_if.slave bus
);
    localparam int AW = $clog2(WORDS);

    reg   [31:0]   mem [0:WORDS-1];
    logic [AW-1:0] widx;

    assign widx      = bus.idx[AW-1:0];
    assign bus.rdata = mem[widx];

    // Byte-lane write on the clock edge; contents are not reset.
    always_ff @(posedge clk) begin
        if (bus.we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: rtl/rv32i_core_regfile.sv
// 32x32 register file, two combinational reads and one clocked write; x0 hardwired to zero.
// Contents are intentionally not reset.
module rv32i_regfile (
    input  logic        clk,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);
    logic [31:0] regFile [0:31];

    // Reads see the pre-edge value, so a same-cycle write is not forwarded.
    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regFile[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regFile[rs2_addr];

    // Write port; writes aimed at x0 are dropped.
    always_ff @(posedge clk) begin
        if (we && rd_addr != 5'd0) regFile[rd_addr] <= rd_data;
    end
endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback retire in one clock.
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024
) (
    input logic clk,
    input logic reset
);
    logic [31:0] pc, pc_in, instruction_mux_out, mux_a_out, mux_b_out, alu_out;
    logic [31:0] imm, rs1_data, rs2_data, rd_data, load_data, pc_plus4;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt, a_sel_pc, b_sel_imm, rd_we, is_store, is_branch, is_jal, is_jalr, take;
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;

    rv32i_core_if imem_bus ();
    rv32i_core_if dmem_bus ();

    rv32i_core_mem #(.WORDS(IMEM_WORDS)) insn_memory (.clk(clk), .bus(imem_bus.slave));
    rv32i_core_mem #(.WORDS(DMEM_WORDS)) data_memory (.clk(clk), .bus(dmem_bus.slave));

    rv32i_regfile register_file (
        .clk(clk), .rs1_addr(rs1), .rs2_addr(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .we(rd_we & ~reset), .rd_addr(rd), .rd_data(rd_data)
    );

    // Fetch; the instruction port is read-only.
    assign imem_bus.idx   = pc[11:2];
    assign imem_bus.we    = 1'b0;
    assign imem_bus.be    = 4'b0000;
    assign imem_bus.wdata = 32'd0;
    assign instruction_mux_out = reset ? NOP_INSN : imem_bus.rdata;

    assign opcode   = instruction_mux_out[6:0];
    assign rd       = instruction_mux_out[11:7];
    assign f3       = instruction_mux_out[14:12];
    assign rs1      = instruction_mux_out[19:15];
    assign rs2      = instruction_mux_out[24:20];
    assign alt      = instruction_mux_out[30];
    assign pc_plus4 = pc + 32'd4;

    // Decode: immediate format, operand selects, ALU op and writeback source.
    always_comb begin
        logic [31:0] i;
        i         = instruction_mux_out;
        imm       = 32'd0;
        a_sel_pc  = 1'b0;
        b_sel_imm = 1'b0;
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        rd_we     = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OP_LUI:    begin imm = {i[31:12], 12'd0}; b_sel_imm = 1'b1; alu_op = ALU_PASS_B; rd_we = 1'b1; end
            OP_AUIPC:  begin imm = {i[31:12], 12'd0}; a_sel_pc = 1'b1; b_sel_imm = 1'b1; rd_we = 1'b1; end
            OP_JAL:    begin
                imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                a_sel_pc = 1'b1; b_sel_imm = 1'b1; rd_we = 1'b1; wb_sel = WB_LINK; is_jal = 1'b1;
            end
            OP_JALR:   begin
                imm = {{20{i[31]}}, i[31:20]};
                b_sel_imm = 1'b1; rd_we = 1'b1; wb_sel = WB_LINK; is_jalr = 1'b1;
            end
            OP_BRANCH: begin
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                a_sel_pc = 1'b1; b_sel_imm = 1'b1; is_branch = 1'b1;
            end
            OP_LOAD:   begin imm = {{20{i[31]}}, i[31:20]}; b_sel_imm = 1'b1; rd_we = 1'b1; wb_sel = WB_LOAD; end
            OP_STORE:  begin imm = {{20{i[31]}}, i[31:25], i[11:7]}; b_sel_imm = 1'b1; is_store = 1'b1; end
            OP_IMM:    begin
                // imm[10] aliases funct7[5]; only SRAI treats it as the alternate bit
                imm = {{20{i[31]}}, i[31:20]}; b_sel_imm = 1'b1; rd_we = 1'b1;
                alu_op = alu_dec(f3, (f3 == 3'b101) && alt);
            end
            OP_REG:    begin rd_we = 1'b1; alu_op = alu_dec(f3, alt); end
            default:   ;
        endcase
    end

    assign mux_a_out = a_sel_pc ? pc : rs1_data;
    assign mux_b_out = b_sel_imm ? imm : rs2_data;

    // ALU; shifts take their amount from operand_b[4:0].
    always_comb begin
        logic [4:0] shamt;
        shamt = mux_b_out[4:0];
        case (alu_op)
            ALU_SUB:    alu_out = mux_a_out - mux_b_out;
            ALU_SLL:    alu_out = mux_a_out << shamt;
            ALU_SLT:    alu_out = {31'd0, $signed(mux_a_out) < $signed(mux_b_out)};
            ALU_SLTU:   alu_out = {31'd0, mux_a_out < mux_b_out};
            ALU_XOR:    alu_out = mux_a_out ^ mux_b_out;
            ALU_SRL:    alu_out = mux_a_out >> shamt;
            ALU_SRA:    alu_out = 32'($signed(mux_a_out) >>> shamt);
            ALU_OR:     alu_out = mux_a_out | mux_b_out;
            ALU_AND:    alu_out = mux_a_out & mux_b_out;
            ALU_PASS_B: alu_out = mux_b_out;
            default:    alu_out = mux_a_out + mux_b_out;
        endcase
    end

    // Branch compare on the raw register operands (the ALU is busy forming the target).
    always_comb begin
        case (f3)
            F3_BEQ:  take = (rs1_data == rs2_data);
            F3_BNE:  take = (rs1_data != rs2_data);
            F3_BLT:  take = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  take = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: take = (rs1_data <  rs2_data);
            F3_BGEU: take = (rs1_data >= rs2_data);
            default: take = 1'b0;
        endcase
    end

    // Next-PC select.
    always_comb begin
        pc_in = pc_plus4;
        if (is_jal || (is_branch && take)) pc_in = alu_out;
        if (is_jalr)                       pc_in = alu_out & ~32'd1;
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) pc <= RESET_PC;
        else       pc <= pc_in;
    end

    // Store lane steering: SB replicates the byte, SH the halfword, enables pick the lanes.
    assign dmem_bus.idx = alu_out[11:2];
    always_comb begin
        dmem_bus.we = is_store & ~reset;
        case (f3[1:0])
            2'b00: begin
                dmem_bus.wdata = {4{rs2_data[7:0]}};
                dmem_bus.be    = 4'b0001 << alu_out[1:0];
            end
            2'b01: begin
                dmem_bus.wdata = {2{rs2_data[15:0]}};
                dmem_bus.be    = alu_out[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dmem_bus.wdata = rs2_data;
                dmem_bus.be    = 4'b1111;
            end
        endcase
    end

    // Load extraction and sign/zero extension.
    always_comb begin
        logic [31:0] bsh, hsh;
        bsh = dmem_bus.rdata >> {alu_out[1:0], 3'b000};
        hsh = dmem_bus.rdata >> {alu_out[1], 4'b0000};
        case (f3)
            F3_B:    load_data = {{24{bsh[7]}}, bsh[7:0]};
            F3_H:    load_data = {{16{hsh[15]}}, hsh[15:0]};
            F3_BU:   load_data = {24'd0, bsh[7:0]};
            F3_HU:   load_data = {16'd0, hsh[15:0]};
            default: load_data = dmem_bus.rdata;
        endcase
    end

    // Writeback source.
    always_comb begin
        case (wb_sel)
            WB_LOAD: rd_data = load_data;
            WB_LINK: rd_data = pc_plus4;
            default: rd_data = alu_out;
        endcase
    end

endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: backdoor preload, run N instructions, compare state.
module tb_rv32i_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    rv32i_core dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    // Hold reset, clear both memories and set regFile[k]=k.
    task automatic setup();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            dut.insn_memory.mem[i] = 32'd0;
            dut.data_memory.mem[i] = 32'd0;
        end
        for (int k = 0; k < 32; k++) dut.register_file.regFile[k] = 32'(k);
    endtask

    // One reset edge after preloading, then let the program run.
    task automatic release_reset();
        @(negedge clk);
        chk("rst_pc", dut.pc, 32'h0);
        chk("rst_nop", dut.instruction_mux_out, NOP);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] xr(input int k);
        return dut.register_file.regFile[k];
    endfunction

    initial begin
        // ADDI / SRAI, then all-zero words
        setup();
        dut.insn_memory.mem[0] = 32'h0320_8093;
        dut.insn_memory.mem[1] = 32'h4010_D113;
        release_reset();
        step(2);
        chk("addi_x1", xr(1), 32'd51);
        chk("srai_x2", xr(2), 32'd25);
        chk("x3_keep", xr(3), 32'd3);
        chk("pc_2", dut.pc, 32'd8);
        step(2);
        chk("nop_pc", dut.pc, 32'd16);
        chk("nop_x1", xr(1), 32'd51);
        chk("nop_x2", xr(2), 32'd25);

        // SRAI / SRLI on a negative value
        setup();
        dut.register_file.regFile[1] = 32'h8000_0000;
        dut.insn_memory.mem[0] = enc_i(12'h404, 5'd1, 3'b101, 5'd2, 7'h13);
        dut.insn_memory.mem[1] = enc_i(12'h004, 5'd1, 3'b101, 5'd3, 7'h13);
        release_reset();
        step(2);
        chk("srai_neg", xr(2), 32'hF800_0000);
        chk("srli_neg", xr(3), 32'h0800_0000);

        // Loads and stores
        setup();
        dut.register_file.regFile[10] = 32'h0000_00FF;
        dut.insn_memory.mem[0] = enc_s(12'd8, 5'd5, 5'd0, 3'b010);          // SW x5,8(x0)
        dut.insn_memory.mem[1] = enc_i(12'd9, 5'd0, 3'b000, 5'd6, 7'h03);   // LB x6,9(x0)
        dut.insn_memory.mem[2] = enc_i(12'd8, 5'd0, 3'b100, 5'd7, 7'h03);   // LBU x7,8(x0)
        dut.insn_memory.mem[3] = enc_s(12'd9, 5'd10, 5'd0, 3'b000);         // SB x10,9(x0)
        dut.insn_memory.mem[4] = enc_i(12'd9, 5'd0, 3'b000, 5'd11, 7'h03);  // LB x11,9(x0)
        dut.insn_memory.mem[5] = enc_i(12'd8, 5'd0, 3'b001, 5'd12, 7'h03);  // LH x12,8(x0)
        dut.insn_memory.mem[6] = enc_i(12'd8, 5'd0, 3'b101, 5'd13, 7'h03);  // LHU x13,8(x0)
        dut.insn_memory.mem[7] = enc_s(12'd14, 5'd10, 5'd0, 3'b001);        // SH x10,14(x0)
        release_reset();
        step(3);
        chk("sw_mem2", dut.data_memory.mem[2], 32'd5);
        chk("lb_x6", xr(6), 32'd0);
        chk("lbu_x7", xr(7), 32'd5);
        step(1);
        chk("sb_mem2", dut.data_memory.mem[2], 32'h0000_FF05);
        step(4);
        chk("lb_neg", xr(11), 32'hFFFF_FFFF);
        chk("lh_x12", xr(12), 32'hFFFF_FF05);
        chk("lhu_x13", xr(13), 32'h0000_FF05);
        chk("sh_hi", dut.data_memory.mem[3], 32'h00FF_0000);

        // Branches
        setup();
        dut.register_file.regFile[22] = 32'hFFFF_FFFF;
        dut.insn_memory.mem[0] = enc_b(13'd8, 5'd1, 5'd1, 3'b000);          // BEQ x1,x1,+8
        dut.insn_memory.mem[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd20, 7'h13);
        dut.insn_memory.mem[2] = enc_i(12'd2, 5'd0, 3'b000, 5'd21, 7'h13);
        dut.insn_memory.mem[3] = enc_b(13'd8, 5'd22, 5'd1, 3'b100);         // BLT -1,1
        dut.insn_memory.mem[4] = enc_i(12'd7, 5'd0, 3'b000, 5'd23, 7'h13);
        dut.insn_memory.mem[5] = enc_b(13'd8, 5'd22, 5'd1, 3'b110);         // BLTU -1,1
        dut.insn_memory.mem[6] = enc_i(12'd9, 5'd0, 3'b000, 5'd24, 7'h13);
        release_reset();
        step(1);
        chk("beq_pc", dut.pc, 32'd8);
        step(1);
        chk("beq_skip", xr(20), 32'd20);
        chk("beq_tgt", xr(21), 32'd2);
        step(1);
        chk("blt_pc", dut.pc, 32'd20);
        step(1);
        chk("bltu_pc", dut.pc, 32'd24);
        step(1);
        chk("blt_skip", xr(23), 32'd23);
        chk("bltu_fall", xr(24), 32'd9);

        // Jumps, x0, upper immediates, compares, mid-program reset
        setup();
        dut.register_file.regFile[3] = 32'd20;
        dut.insn_memory.mem[0]  = enc_j(21'd16, 5'd1);                      // JAL x1,+16
        dut.insn_memory.mem[4]  = enc_i(12'd1, 5'd3, 3'b000, 5'd0, 7'h67);  // JALR x0,x3,1
        dut.insn_memory.mem[5]  = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'h13);  // ADDI x0,x0,5
        dut.insn_memory.mem[6]  = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd25);  // ADD x25,x0,x0
        dut.insn_memory.mem[7]  = enc_u(20'h12345, 5'd26, 7'h37);           // LUI
        dut.insn_memory.mem[8]  = enc_u(20'h00001, 5'd27, 7'h17);           // AUIPC at pc=32
        dut.insn_memory.mem[9]  = enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd28);  // SUB x28,x0,x1
        dut.insn_memory.mem[10] = enc_r(7'h00, 5'd1, 5'd28, 3'b010, 5'd29); // SLT
        dut.insn_memory.mem[11] = enc_r(7'h00, 5'd1, 5'd28, 3'b011, 5'd30); // SLTU
        dut.insn_memory.mem[13] = enc_i(12'd99, 5'd0, 3'b000, 5'd1, 7'h13); // ADDI x1,x0,99
        release_reset();
        step(1);
        chk("jal_x1", xr(1), 32'd4);
        chk("jal_pc", dut.pc, 32'd16);
        step(1);
        chk("jalr_pc", dut.pc, 32'd20);
        step(8);
        chk("run_pc", dut.pc, 32'd52);
        chk("x0_zero", xr(0), 32'd0);
        chk("add_x0", xr(25), 32'd0);
        chk("lui", xr(26), 32'h1234_5000);
        chk("auipc", xr(27), 32'h0000_1020);
        chk("sub", xr(28), 32'hFFFF_FFFC);
        chk("slt", xr(29), 32'd1);
        chk("sltu", xr(30), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pc", dut.pc, 32'd0);
        chk("mid_rst_x1", xr(1), 32'd4);
        chk("mid_rst_x26", xr(26), 32'h1234_5000);
        reset = 1'b0;
        step(1);
        chk("rerun_pc", dut.pc, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
